// File: rtl/shift_reg_var.sv
// shift_reg_var: multi-lane, stallable, flushable delay line whose tap
// (delay in stages) is selected at run time through dly_sel.
module shift_reg_var #(
  parameter int MAX_DELAY = 8,
  parameter int WIDTH     = 3,
  parameter int NUB       = 1,
  parameter int SEL_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic [SEL_W-1:0]     dly_sel,
  input  logic [NUB-1:0]       vld_in,
  input  logic [WIDTH*NUB-1:0] port_in,
  output logic [NUB-1:0]       vld_out,
  output logic [WIDTH*NUB-1:0] port_out,
  output logic                 busy,
  output logic                 dly_err
);

  logic [NUB-1:0]       v_q [MAX_DELAY];
  logic [WIDTH*NUB-1:0] d_q [MAX_DELAY];
  logic [SEL_W-1:0]     d_eff;
  logic [NUB-1:0]       tap_v;
  logic [WIDTH*NUB-1:0] tap_d;

  // Clamp the requested delay to the number of stages actually built.
  always_comb begin
    d_eff = (dly_sel > SEL_W'(MAX_DELAY)) ? SEL_W'(MAX_DELAY) : dly_sel;
  end

  // Stage storage: flush beats advance, advance beats hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < unsigned'(MAX_DELAY); k++) begin
        v_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else if (flush) begin
      for (int unsigned k = 0; k < unsigned'(MAX_DELAY); k++) begin
        v_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0] <= vld_in;
      d_q[0] <= port_in;
      for (int unsigned k = 1; k < unsigned'(MAX_DELAY); k++) begin
        v_q[k] <= v_q[k-1];
        d_q[k] <= d_q[k-1];
      end
    end
  end

  // Out-of-range select flag, sampled every clock independent of en/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_err <= 1'b0;
    end else begin
      dly_err <= (dly_sel > SEL_W'(MAX_DELAY));
    end
  end

  // Tap mux: delay 0 bypasses storage, delay D selects stage D-1.
  always_comb begin
    tap_v = '0;
    tap_d = '0;
    if (d_eff == '0) begin
      tap_v = vld_in;
      tap_d = port_in;
    end else begin
      for (int unsigned k = 0; k < unsigned'(MAX_DELAY); k++) begin
        if (d_eff == SEL_W'(k + 1)) begin
          tap_v = v_q[k];
          tap_d = d_q[k];
        end
      end
    end
  end

  // Per-lane output masking; reset also blanks the bypass path at once.
  always_comb begin
    vld_out  = '0;
    port_out = '0;
    for (int unsigned j = 0; j < unsigned'(NUB); j++) begin
      if (rst_n && tap_v[j]) begin
        vld_out[j]                  = 1'b1;
        port_out[j*WIDTH +: WIDTH]  = tap_d[j*WIDTH +: WIDTH];
      end
    end
  end

  // Occupancy: any valid word in any stored stage, regardless of tap.
  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k < unsigned'(MAX_DELAY); k++) begin
      busy = busy | (|v_q[k]);
    end
  end

endmodule
